reg_writeback_rf: RTL and testbench

REG_WRITEBACK_RF -- requirements
Module: reg_writeback_rf

---
 rtl/reg_writeback_rf_if.sv | 38 +++
 rtl/reg_writeback_rf.sv | 91 +++++++++
 tb/tb_reg_writeback_rf.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_rf_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_writeback_rf_if
// Purpose  : Writeback, issue and read-port signal bundle for reg_writeback_rf.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface reg_writeback_rf_if;
  logic        en_wb;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [31:0] wb_memdata;
  logic [31:0] wb_aluout;
  logic [4:0]  wb_rd;
  logic        iss_valid;
  logic        iss_regwrite;
  logic [4:0]  iss_rd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_busy;
  logic        rt_busy;
  logic [31:0] wb_data;
  logic        err;

  modport master (
    output en_wb, wb_regwrite, wb_memtoreg, wb_memdata, wb_aluout, wb_rd,
    output iss_valid, iss_regwrite, iss_rd, rs_addr, rt_addr,
    input  rs_data, rt_data, rs_busy, rt_busy, wb_data, err
  );

  modport slave (
    input  en_wb, wb_regwrite, wb_memtoreg, wb_memdata, wb_aluout, wb_rd,
    input  iss_valid, iss_regwrite, iss_rd, rs_addr, rt_addr,
    output rs_data, rt_data, rs_busy, rt_busy, wb_data, err
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_rf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_writeback_rf
// Purpose  : 32x32 register file with writeback mux, write-through read
//            bypass and a per-register pending-write scoreboard.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module reg_writeback_rf (
  input wire logic          clk,
  input wire logic          reset,
  reg_writeback_rf_if.slave bus
);

  logic [31:0] r_regs    [32];
  logic [1:0]  r_cnt     [32];
  logic        r_err;

  logic [1:0]  w_cnt_nxt [32];
  logic        w_err_set;
  logic        w_commit;
  logic        w_issue;
  logic [31:0] w_wb_data;

  assign w_wb_data = bus.wb_memtoreg ? bus.wb_memdata : bus.wb_aluout;
  assign w_commit  = bus.en_wb & bus.wb_regwrite & (bus.wb_rd != 5'd0);
  assign w_issue   = bus.iss_valid & bus.iss_regwrite & (bus.iss_rd != 5'd0);

  // Entry 0 is never written, so it always reads as zero via the explicit guard.
  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0)
      return 32'd0;
    else if (w_commit && (addr == bus.wb_rd))
      return w_wb_data;
    else
      return r_regs[addr];
  endfunction

  // A single outstanding write being committed now is satisfied by the bypass.
  function automatic logic busy_port(input logic [4:0] addr);
    if (addr == 5'd0)
      return 1'b0;
    else if ((r_cnt[addr] == 2'd1) && w_commit && (addr == bus.wb_rd))
      return 1'b0;
    else
      return (r_cnt[addr] != 2'd0);
  endfunction

  assign bus.wb_data = w_wb_data;
  assign bus.rs_data = read_port(bus.rs_addr);
  assign bus.rt_data = read_port(bus.rt_addr);
  assign bus.rs_busy = busy_port(bus.rs_addr);
  assign bus.rt_busy = busy_port(bus.rt_addr);
  assign bus.err     = r_err;

  always_comb begin
    w_err_set = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_issue && (bus.iss_rd == 5'(i)) && !(w_commit && (bus.wb_rd == 5'(i)))) begin
        if (r_cnt[i] == 2'd3)
          w_err_set = 1'b1;
        else
          w_cnt_nxt[i] = r_cnt[i] + 2'd1;
      end else if (w_commit && (bus.wb_rd == 5'(i)) && !(w_issue && (bus.iss_rd == 5'(i)))) begin
        if (r_cnt[i] == 2'd0)
          w_err_set = 1'b1;
        else
          w_cnt_nxt[i] = r_cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
        r_cnt[i]  <= 2'd0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_commit)
        r_regs[bus.wb_rd] <= w_wb_data;
      for (int i = 0; i < 32; i++)
        r_cnt[i] <= w_cnt_nxt[i];
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_rf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_reg_writeback_rf
// Purpose  : Scoreboard bench for reg_writeback_rf against a reference model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_reg_writeback_rf;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wb;
    logic        rsb;
    logic        rtb;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  reg_writeback_rf_if bus();

  reg_writeback_rf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;
  exp_t        sb_q   [$];
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_cnt[i]  = 0;
    end
    m_err = 1'b0;
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic cyc(input logic rst, input logic en, input logic rw, input logic mtr,
                     input logic [31:0] md, input logic [31:0] alu, input logic [4:0] wrd,
                     input logic iv, input logic ir, input logic [4:0] ird,
                     input logic [4:0] rsa, input logic [4:0] rta);
    exp_t        e;
    exp_t        a;
    logic        com;
    logic        iss;
    logic [31:0] wbd;
    reset            = rst;
    bus.en_wb        = en;
    bus.wb_regwrite  = rw;
    bus.wb_memtoreg  = mtr;
    bus.wb_memdata   = md;
    bus.wb_aluout    = alu;
    bus.wb_rd        = wrd;
    bus.iss_valid    = iv;
    bus.iss_regwrite = ir;
    bus.iss_rd       = ird;
    bus.rs_addr      = rsa;
    bus.rt_addr      = rta;

    wbd = mtr ? md : alu;
    com = en && rw && (wrd != 5'd0);
    iss = iv && ir && (ird != 5'd0);
    e.wb  = wbd;
    e.err = m_err;
    e.rs  = (rsa == 5'd0) ? 32'd0 : (com && rsa == wrd) ? wbd : m_regs[rsa];
    e.rt  = (rta == 5'd0) ? 32'd0 : (com && rta == wrd) ? wbd : m_regs[rta];
    e.rsb = (rsa != 5'd0) && (m_cnt[rsa] != 0) && !(m_cnt[rsa] == 1 && com && wrd == rsa);
    e.rtb = (rta != 5'd0) && (m_cnt[rta] != 0) && !(m_cnt[rta] == 1 && com && wrd == rta);
    sb_q.push_back(e);

    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      a = sb_q.pop_front();
      check("rs_data", bus.rs_data, a.rs);
      check("rt_data", bus.rt_data, a.rt);
      check("wb_data", bus.wb_data, a.wb);
      check("rs_busy", {31'd0, bus.rs_busy}, {31'd0, a.rsb});
      check("rt_busy", {31'd0, bus.rt_busy}, {31'd0, a.rtb});
      check("err",     {31'd0, bus.err},     {31'd0, a.err});
    end

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (com)
        m_regs[wrd] = wbd;
      if (!(iss && com && ird == wrd)) begin
        if (iss) begin
          if (m_cnt[ird] == 3) m_err = 1'b1;
          else                 m_cnt[ird]++;
        end
        if (com) begin
          if (m_cnt[wrd] == 0) m_err = 1'b1;
          else                 m_cnt[wrd]--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] rsa, input logic [4:0] rta);
    cyc(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, rsa, rta);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    clk      = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus.en_wb = 0; bus.wb_regwrite = 0; bus.wb_memtoreg = 0;
    bus.wb_memdata = 0; bus.wb_aluout = 0; bus.wb_rd = 0;
    bus.iss_valid = 0; bus.iss_regwrite = 0; bus.iss_rd = 0;
    bus.rs_addr = 0; bus.rt_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Post-reset state, wb_data still muxed
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h1111_2222, 5'd0, 0, 0, 5'd0, 5'd5, 5'd31);
    cyc(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h1111_2222, 5'd0, 0, 0, 5'd0, 5'd1, 5'd2);

    // Basic write with same-cycle bypass, then stored read with en_wb low
    cyc(0, 1, 1, 0, 32'hAAAA_AAAA, 32'h1234_5678, 5'd5, 0, 0, 5'd0, 5'd5, 5'd0);
    cyc(0, 0, 1, 0, 32'hAAAA_AAAA, 32'h9999_9999, 5'd5, 0, 0, 5'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd6);
    do_reset();

    // Zero register write is discarded and never flags
    cyc(0, 1, 1, 1, 32'hFFFF_FFFF, 32'd0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Issue then commit to r7
    cyc(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 1, 1, 5'd7, 5'd7, 5'd7);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd7);
    cyc(0, 1, 1, 1, 32'hCAFE_0007, 32'd0, 5'd7, 0, 0, 5'd0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);

    // Simultaneous issue and commit to r9 with one outstanding
    cyc(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 1, 1, 5'd9, 5'd9, 5'd0);
    cyc(0, 1, 1, 0, 32'd0, 32'h0000_0909, 5'd9, 1, 1, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    cyc(0, 0, 1, 0, 32'd0, 32'h0000_1111, 5'd9, 1, 0, 5'd9, 5'd9, 5'd9);

    // Counter saturation on r3
    for (int k = 0; k < 4; k++)
      cyc(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 1, 1, 5'd3, 5'd3, 5'd0);
    idle(5'd3, 5'd3);
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 1, 0, 32'd0, 32'h300 + k, 5'd3, 0, 0, 5'd0, 5'd3, 5'd0);
    idle(5'd3, 5'd3);
    do_reset();

    // Underflow commit still writes
    cyc(0, 1, 1, 0, 32'd0, 32'h0000_0444, 5'd4, 0, 0, 5'd0, 5'd4, 5'd0);
    idle(5'd4, 5'd4);
    do_reset();

    // Fill all registers, two pending on r2, then reset with a commit to r2
    for (int r = 1; r < 32; r++)
      cyc(0, 1, 1, r[0], 32'hA000_0000 + r, 32'h5000_0000 + r, 5'(r), 0, 0, 5'd0, 5'(r), 5'(r - 1));
    cyc(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 1, 1, 5'd2, 5'd2, 5'd3);
    cyc(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 1, 1, 5'd2, 5'd2, 5'd3);
    cyc(1, 1, 1, 0, 32'd0, 32'h2222_2222, 5'd2, 1, 1, 5'd2, 5'd2, 5'd3);
    idle(5'd2, 5'd3);
    for (int r = 1; r < 32; r += 2)
      idle(5'(r), 5'(r + 1));

    // Random traffic on a narrow address range to exercise collisions
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom, $urandom, 5'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if ((n % 50) == 49) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
